// File: rtl/ahb3lite_dma_arbiter_pkg.sv
// Shared AHB3-Lite types and encodings for the two-master DMA arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ahb3lite_dma_arbiter_pkg;

    // AMBA AHB3-Lite transfer type
    typedef logic [1:0] HTRANS_state;
    localparam HTRANS_state HTRANS_IDLE   = 2'b00;
    localparam HTRANS_state HTRANS_BUSY   = 2'b01;
    localparam HTRANS_state HTRANS_NONSEQ = 2'b10;
    localparam HTRANS_state HTRANS_SEQ    = 2'b11;

    // AMBA AHB3-Lite burst type
    typedef logic [2:0] HBURST_Type;
    localparam HBURST_Type HBURST_SINGLE = 3'b000;
    localparam HBURST_Type HBURST_INCR   = 3'b001;
    localparam HBURST_Type HBURST_WRAP4  = 3'b010;
    localparam HBURST_Type HBURST_INCR4  = 3'b011;
    localparam HBURST_Type HBURST_WRAP8  = 3'b100;
    localparam HBURST_Type HBURST_INCR8  = 3'b101;
    localparam HBURST_Type HBURST_WRAP16 = 3'b110;
    localparam HBURST_Type HBURST_INCR16 = 3'b111;

    // AMBA AHB3-Lite response
    typedef logic HRESP_state;
    localparam HRESP_state HRESP_OKAY  = 1'b0;
    localparam HRESP_state HRESP_ERROR = 1'b1;

    // Arbiter FSM encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE  = 2'd0;
    localparam arb_state_t ARB_OWN   = 2'd1;
    localparam arb_state_t ARB_DRAIN = 2'd2;

    // One-hot winner among two requesters; ptr breaks the tie when both request.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        logic [1:0] win;
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = ptr ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
        return win;
    endfunction

endpackage

// File: rtl/ahb3lite_dma_arbiter_if.sv
// Bundle of the per-master request/address-phase inputs and the muxed slave side.
// Latency: none (wires only).
// Backpressure: HREADY travels slave -> arbiter -> masters through this bundle.
interface ahb3lite_dma_arbiter_if;
    import ahb3lite_dma_arbiter_pkg::*;

    logic [1:0]              i_req;
    logic [1:0][31:0]        i_HADDR_m;
    HTRANS_state [1:0]       i_HTRANS_m;
    logic [1:0]              i_HWRITE_m;
    logic [1:0][2:0]         i_HSIZE_m;
    HBURST_Type [1:0]        i_HBURST_m;
    logic                    i_HREADY;
    logic                    i_HRDATA_En;

    logic [1:0]              o_grant;
    logic [31:0]             o_HADDR;
    HTRANS_state             o_HTRANS;
    logic                    o_HWRITE;
    logic [2:0]              o_HSIZE;
    HBURST_Type              o_HBURST;
    logic [1:0]              o_HREADY_m;
    logic [1:0]              o_HRDATA_En_m;
    logic                    o_busy;

    // Arbiter view: it serves the masters and drives the shared slave port.
    modport slave (
        input  i_req, i_HADDR_m, i_HTRANS_m, i_HWRITE_m, i_HSIZE_m, i_HBURST_m,
        input  i_HREADY, i_HRDATA_En,
        output o_grant, o_HADDR, o_HTRANS, o_HWRITE, o_HSIZE, o_HBURST,
        output o_HREADY_m, o_HRDATA_En_m, o_busy
    );

    // Bus-master / environment view.
    modport master (
        output i_req, i_HADDR_m, i_HTRANS_m, i_HWRITE_m, i_HSIZE_m, i_HBURST_m,
        output i_HREADY, i_HRDATA_En,
        input  o_grant, o_HADDR, o_HTRANS, o_HWRITE, o_HSIZE, o_HBURST,
        input  o_HREADY_m, o_HRDATA_En_m, o_busy
    );

endinterface

// File: rtl/ahb3lite_beat_counter.sv
// Counts accepted beats of the current tenure and flags when the budget is spent.
// Latency: count updates on the edge after the beat; budget_hit is combinational on the count.
// Backpressure: only counts when the caller qualifies inc with HREADY; saturates, never wraps.
module ahb3lite_beat_counter #(
    parameter int MAX_GRANT_BEATS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic budget_hit
);

    localparam int CW = $clog2(MAX_GRANT_BEATS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_GRANT_BEATS);

    logic [CW-1:0] cnt;

    // Clear at tenure start, otherwise count beats up to the budget and hold there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign budget_hit = (cnt >= CNT_MAX);

endmodule

// File: rtl/ahb3lite_dma_arbiter.sv
// Two-master AHB3-Lite arbiter: round-robin grant, burst-safe handover, muxed address phase.
// Latency: grant one edge after request; data-phase routing lags the address phase by one accepted cycle.
// Backpressure: the slave's HREADY stalls both phase owners; any other master sees HREADY=0.
module ahb3lite_dma_arbiter
    import ahb3lite_dma_arbiter_pkg::*;
#(
    parameter int MAX_GRANT_BEATS = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    ahb3lite_dma_arbiter_if.slave   bus
);

    arb_state_t  state;
    logic [1:0]  grant;
    logic [1:0]  data_owner;
    logic        rr_ptr;

    logic        own_idx;
    logic        other_idx;
    HTRANS_state own_trans;
    logic        own_req;
    logic        other_req;
    logic        req_any;
    logic [1:0]  winner;
    logic        beat_xfer;
    logic        budget_hit;
    logic        release_own;
    logic        start_tenure;

    assign own_idx   = grant[1];
    assign other_idx = ~own_idx;
    assign own_trans = bus.i_HTRANS_m[own_idx];
    assign own_req   = bus.i_req[own_idx];
    assign other_req = bus.i_req[other_idx];
    assign req_any   = |bus.i_req;
    assign winner    = rr_pick(bus.i_req, rr_ptr);

    // A beat is an accepted NONSEQ/SEQ address phase of the current owner.
    assign beat_xfer = (state == ARB_OWN) && bus.i_HREADY &&
                       ((own_trans == HTRANS_NONSEQ) || (own_trans == HTRANS_SEQ));

    // Leave only at a burst boundary: never while the owner shows SEQ or BUSY.
    assign release_own = (state == ARB_OWN) && bus.i_HREADY &&
                         ((!own_req && (own_trans == HTRANS_IDLE)) ||
                          (budget_hit && other_req &&
                           ((own_trans == HTRANS_NONSEQ) || (own_trans == HTRANS_IDLE))));

    // A fresh tenure begins from idle, or as the drain completes with someone waiting.
    assign start_tenure = req_any &&
                          ((state == ARB_IDLE) || ((state == ARB_DRAIN) && bus.i_HREADY));

    ahb3lite_beat_counter #(
        .MAX_GRANT_BEATS (MAX_GRANT_BEATS)
    ) u_beat_counter (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .clr        (start_tenure),
        .inc        (beat_xfer),
        .budget_hit (budget_hit)
    );

    // Arbitration FSM, grant register, round-robin pointer and data-phase owner.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state      <= ARB_IDLE;
            grant      <= 2'b00;
            data_owner <= 2'b00;
            rr_ptr     <= 1'b0;
        end else begin
            if (bus.i_HREADY) begin
                data_owner <= grant;
            end
            case (state)
                ARB_IDLE: begin
                    if (req_any) begin
                        state <= ARB_OWN;
                        grant <= winner;
                    end
                end
                ARB_OWN: begin
                    if (release_own) begin
                        state  <= ARB_DRAIN;
                        grant  <= 2'b00;
                        rr_ptr <= other_idx;
                    end
                end
                ARB_DRAIN: begin
                    if (bus.i_HREADY) begin
                        state <= req_any ? ARB_OWN : ARB_IDLE;
                        grant <= winner;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Slave-side address phase: the owner's signals, or an idle SINGLE when nobody owns the bus.
    always_comb begin
        bus.o_HADDR  = 32'h0;
        bus.o_HTRANS = HTRANS_IDLE;
        bus.o_HWRITE = 1'b0;
        bus.o_HSIZE  = 3'b000;
        bus.o_HBURST = HBURST_SINGLE;
        if (|grant) begin
            bus.o_HADDR  = bus.i_HADDR_m[own_idx];
            bus.o_HTRANS = own_trans;
            bus.o_HWRITE = bus.i_HWRITE_m[own_idx];
            bus.o_HSIZE  = bus.i_HSIZE_m[own_idx];
            bus.o_HBURST = bus.i_HBURST_m[own_idx];
        end
    end

    assign bus.o_grant       = grant;
    assign bus.o_HREADY_m    = (grant | data_owner) & {2{bus.i_HREADY}};
    assign bus.o_HRDATA_En_m = data_owner & {2{bus.i_HRDATA_En}};
    assign bus.o_busy        = (state != ARB_IDLE);

endmodule

// File: doc/ahb3lite_dma_arbiter.md
AHB3LITE_DMA_ARBITER -- requirements
Module: ahb3lite_dma_arbiter

Interface
REQ-001 Parameter MAX_GRANT_BEATS, default 16, is the beat budget per tenure before forced re-arbitration at the next burst boundary.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset: HCLK and HRESETn.
REQ-003 HCLK  input  1  bus clock; all state updates on rising edge.
REQ-004 HRESETn  input  1  synchronous active-low reset.
REQ-005 i_req  input  2  per-master bus request, level; bit0 = CoreSystemDMA master, bit1 = second master.
REQ-006 i_HADDR_m  input  2x32  per-master HADDR (index = master).
REQ-007 i_HTRANS_m  input  2xHTRANS_state  per-master HTRANS.
REQ-008 i_HWRITE_m / i_HSIZE_m / i_HBURST_m  input  2x1 / 2x3 / 2xHBURST_Type  per-master control.
REQ-009 i_HREADY  input  1  HREADYOUT from the shared slave.
REQ-010 i_HRDATA_En  input  1  slave read-data strobe.
REQ-011 o_grant  output  2  one-hot address-phase owner; 00 = no owner.
REQ-012 o_HADDR / o_HTRANS / o_HWRITE / o_HSIZE / o_HBURST  output  32/2/1/3/3  muxed address phase to slave.
REQ-013 o_HREADY_m  output  2  per-master HREADY.
REQ-014 o_HRDATA_En_m  output  2  i_HRDATA_En routed to the data-phase owner.
REQ-015 o_busy  output  1  high while any tenure is active or draining.

Function
REQ-016 The FSM SHALL have states ARB_IDLE, ARB_OWN and ARB_DRAIN.
REQ-017 ARB_IDLE -> ARB_OWN SHALL occur on the first edge with i_req != 0; the winner is set in o_grant and the beat counter is cleared.
REQ-018 On simultaneous requests, the winner SHALL be the master named by the round-robin pointer.
REQ-019 The round-robin pointer SHALL toggle to the other master after every completed tenure.
REQ-020 ARB_OWN -> ARB_DRAIN SHALL occur on an edge with i_HREADY=1 when either condition holds: (a) the owner's i_req=0 and its HTRANS=IDLE; or (b) beat count >= MAX_GRANT_BEATS, the owner presents NONSEQ or IDLE, and the other master requests.
REQ-021 Grant SHALL never be removed while the owner presents SEQ or BUSY.
REQ-022 The beat counter SHALL increment on each edge with i_HREADY=1 and owner HTRANS in {NONSEQ, SEQ}.
REQ-023 The beat counter SHALL saturate at MAX_GRANT_BEATS and not wrap.
REQ-024 In ARB_DRAIN, o_grant SHALL be 00 and o_HTRANS SHALL be IDLE.
REQ-025 ARB_DRAIN SHALL exit on the first edge with i_HREADY=1 (last data phase complete): to ARB_OWN if any i_req, else to ARB_IDLE.
REQ-026 Data-phase owner SHALL be loaded from o_grant on each edge with i_HREADY=1, giving exactly one cycle of lag behind the address phase.
REQ-027 The slave-side address phase SHALL be a combinational mux of the owner's signals.
REQ-028 With no owner, the slave-side address phase SHALL be HADDR=0, HTRANS=IDLE, HWRITE=0, HSIZE=0, HBURST=SINGLE.
REQ-029 o_HREADY_m SHALL be i_HREADY for the address owner and for the data-phase owner, and 0 for any other master (stalls the non-owner).
REQ-030 o_HRDATA_En_m SHALL be i_HRDATA_En for the data-phase owner only; the other bit is 0.
REQ-031 A request dropped by a non-owner SHALL be ignored.
REQ-032 A request asserted during ARB_DRAIN SHALL be considered at drain exit.

Reset
REQ-033 While HRESETn=0 at an edge, the block SHALL enter ARB_IDLE.
REQ-034 Reset values SHALL be: o_grant=00, data owner=none, pointer=master0, beat counter=0, o_busy=0, all o_HRDATA_En_m=0.
REQ-035 Reset mid-burst SHALL abort immediately, with no drain.

Structure
REQ-036 arb_state_t and the HTRANS/HBURST encoding constants SHALL live in the shared ahb3lite package alongside HTRANS_state, HBURST_Type and HRESP_state.
REQ-037 The beat counter with its saturation and budget compare SHALL be one sub-module, ahb3lite_beat_counter; the FSM and muxes stay in the top.

Verification
REQ-038 Scenario 1: after reset, i_req=01, M0 issues INCR4 at 0x1000, HREADY=1 -> o_grant=01 next edge; o_HADDR 0x1000..0x100C; o_HRDATA_En_m=01 on all 4 strobes.
REQ-039 Scenario 2: i_req=11 on the same edge, pointer=0 -> M0 granted first; after M0 drops req and drains, M1 granted; o_HREADY_m[1]=0 throughout M0's tenure.
REQ-040 Scenario 3: MAX_GRANT_BEATS=4, M0 issues INCR8 while M1 requests -> no switch mid-burst; switch only at M0's next NONSEQ after beat 8.
REQ-041 Scenario 4: slave holds HREADY=0 for 3 cycles during ARB_DRAIN -> o_grant stays 00 and o_HTRANS=IDLE for 3 cycles; M1 granted on the first edge with HREADY=1.
REQ-042 Scenario 5: HRESETn=0 for one edge mid-INCR4 -> next cycle o_grant=00, o_HTRANS=IDLE, o_busy=0, pointer=master0.
